// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants, instruction field positions and decode record.
package mips_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned FIELD_W = 5;

   localparam int unsigned OP_HI = 31;
   localparam int unsigned OP_LO = 26;
   localparam int unsigned RT_HI = 20;
   localparam int unsigned RT_LO = 16;
   localparam int unsigned RD_HI = 15;
   localparam int unsigned RD_LO = 11;
   localparam int unsigned FN_HI = 5;
   localparam int unsigned FN_LO = 0;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_DM  = 2'd1;
   localparam logic [1:0] WD_PC8 = 2'd2;

   localparam logic [FIELD_W-1:0] REG_RA = 5'd31;

   typedef struct packed {
      logic [FIELD_W-1:0] a3;
      logic               wr;
      logic [1:0]         wd_sel;
      logic [1:0]         tnew_base;
      logic               is_slt;
   } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decode: destination, write enable, write-data
// source and E-stage-relative Tnew. Shared by the D-stage controller.
module instr_decode
   import mips_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output dec_t               dec
);

   logic [5:0]         op;
   logic [5:0]         fn;
   logic [FIELD_W-1:0] rt;
   logic [FIELD_W-1:0] rd;
   logic               unused_fields;

   assign op = instr[OP_HI:OP_LO];
   assign fn = instr[FN_HI:FN_LO];
   assign rt = instr[RT_HI:RT_LO];
   assign rd = instr[RD_HI:RD_LO];
   // rs and shamt never select a destination
   assign unused_fields = ^{instr[25:21], instr[10:6]};

   // Anything not listed (including sw, beq, j, jr) decodes as a NOP
   always_comb begin
      dec = '0;
      case (op)
         OP_R: begin
            case (fn)
               FN_ADDU, FN_SUBU: begin
                  dec.a3        = rd;
                  dec.wr        = 1'b1;
                  dec.tnew_base = 2'd1;
               end
               FN_SLT: begin
                  dec.a3        = rd;
                  dec.wr        = 1'b1;
                  dec.tnew_base = 2'd1;
                  dec.is_slt    = 1'b1;
               end
               default: dec = '0;
            endcase
         end
         OP_ORI, OP_LUI: begin
            dec.a3        = rt;
            dec.wr        = 1'b1;
            dec.tnew_base = 2'd1;
         end
         OP_LW: begin
            dec.a3        = rt;
            dec.wr        = 1'b1;
            dec.wd_sel    = WD_DM;
            dec.tnew_base = 2'd2;
         end
         OP_JAL: begin
            dec.a3     = REG_RA;
            dec.wr     = 1'b1;
            dec.wd_sel = WD_PC8;
         end
         default: dec = '0;
      endcase
   end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// One pipeline register plus per-stage decode (A3, regwrite, wd_sel, Tnew); the W
// instance also counts retired instructions. COND_WB_EN adds a conditional slt write.
module pipe_stage_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned STAGE   = 3,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               valid_in,
   input  logic [DATA_W-1:0]  instr_in,
   input  logic [DATA_W-1:0]  pc_in,
   input  logic               cond_in,
   output logic               valid,
   output logic [DATA_W-1:0]  instr,
   output logic [DATA_W-1:0]  pc,
   output logic [RADDR_W-1:0] A3,
   output logic               regwrite,
   output logic [1:0]         wd_sel,
   output logic [1:0]         Tnew,
   output logic [CNT_W-1:0]   retire_cnt
);

   if (STAGE < 1 || STAGE > 3) begin : g_bad_stage
      $error("pipe_stage_ctrl: STAGE must be 1, 2 or 3");
   end
   if (DATA_W < INSTR_W || RADDR_W < FIELD_W) begin : g_bad_width
      $error("pipe_stage_ctrl: DATA_W must be >= 32 and RADDR_W >= 5");
   end

   localparam logic [1:0] STAGE_OFS = 2'(STAGE - 1);

   dec_t dec;
   logic load;
   logic cond_ok;

   assign load = !flush && !stall;

   // Pipeline register: reset > flush > stall > load
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (!stall) begin
         valid <= valid_in;
         instr <= instr_in;
         pc    <= pc_in;
      end
   end

`ifdef COND_WB_EN
   logic cond_q;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         cond_q <= 1'b0;
      end else if (!stall) begin
         cond_q <= cond_in;
      end
   end

   assign cond_ok = !dec.is_slt || cond_q;
`else
   logic unused_cond;

   assign unused_cond = ^{cond_in, dec.is_slt};
   assign cond_ok     = 1'b1;
`endif

   instr_decode u_decode (
      .instr (instr[INSTR_W-1:0]),
      .dec   (dec)
   );

   // Bubbles decode to all-zero; $0 is never written
   always_comb begin
      A3       = '0;
      regwrite = 1'b0;
      wd_sel   = WD_ALU;
      Tnew     = 2'd0;
      if (valid) begin
         A3       = RADDR_W'(dec.a3);
         regwrite = dec.wr && cond_ok && (dec.a3 != '0);
         wd_sel   = dec.wd_sel;
         Tnew     = (dec.tnew_base > STAGE_OFS) ? (dec.tnew_base - STAGE_OFS) : 2'd0;
      end
   end

   if (STAGE == 3) begin : g_retire
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= '0;
         end else if (load && valid_in) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign retire_cnt = cnt_q;
   end else begin : g_no_retire
      assign retire_cnt = '0;
   end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Parametrised successor to the fixed writeback-stage decoder in the 5-stage MIPS pipeline.
- Combines one pipeline register (instr, pc, valid) with the per-stage decode of A3, regwrite, write-data select and stage-relative Tnew.
- One instance per stage: E, M and W. The W instance also keeps a retired-instruction counter.
- Feeds the hazard/forwarding unit (A3, Tnew, regwrite) and the GRF write port (W instance).

Parameters:
- STAGE, 3, pipeline stage index: 1=E, 2=M, 3=W. Other values are illegal and trip an elaboration-time check.
- DATA_W, 32, width of instr and pc.
- RADDR_W, 5, register-address width; instr fields are always 5 bits and zero-extended to RADDR_W.
- CNT_W, 32, width of retire_cnt.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the register contents
- flush  in  1  load a bubble
- valid_in  in  1  upstream instr is real
- instr_in  in  DATA_W  instr from previous stage
- pc_in  in  DATA_W  pc from previous stage
- cond_in  in  1  conditional-write qualifier (used only with COND_WB_EN)
- valid  out  1  registered valid
- instr  out  DATA_W  registered instr
- pc  out  DATA_W  registered pc
- A3  out  RADDR_W  destination register
- regwrite  out  1  GRF write enable
- wd_sel  out  2  write-data select: 0=ALU, 1=DM, 2=PC+8
- Tnew  out  2  cycles until the result exists, counted from this stage
- retire_cnt  out  CNT_W  retired instructions; W instance only, tied 0 otherwise

Behaviour:
- Register update priority: reset > flush > stall > load.
  - reset: instr=0, pc=0, valid=0, retire_cnt=0.
  - flush: instr=0, pc=0, valid=0; flush beats stall when both are asserted.
  - stall: hold instr, pc, valid (and any cond latch).
  - otherwise load instr_in, pc_in, valid_in.
- All decode outputs are combinational from the registered instr and valid, so latency from instr_in to outputs is 1 cycle.
- valid=0: A3=0, regwrite=0, wd_sel=0, Tnew=0.
- Decode table; base Tnew is the E-stage value:
  - addu (op 0, fn 0x21), subu (fn 0x23), slt (fn 0x2A): A3=rd, wd_sel=0, base 1.
  - ori (0x0D), lui (0x0F): A3=rt, wd_sel=0, base 1.
  - lw (0x23): A3=rt, wd_sel=1, base 2.
  - jal (0x03): A3=31, wd_sel=2, base 0.
  - sw, beq, j (op 0x02), jr (op 0, fn 0x08), anything else: A3=0, regwrite=0, base 0.
- Tnew = max(base - (STAGE-1), 0), saturating at 0; W instance always outputs 0.
- regwrite = decoded write AND (A3 != 0). $0 is never written.
- retire_cnt (STAGE==3 only): increments on each edge where the register loads valid_in=1 with no reset, flush or stall. Wraps modulo 2^CNT_W without saturating.
- Reset mid-stall or mid-flush: reset wins; all outputs reach their reset values the next cycle.
- Unknown opcode or funct: treated as NOP, with no X propagation.

Optional Feature:
- Macro COND_WB_EN enables conditional writeback for slt-class instructions (the old "change" flag).
- With the macro: cond_in is registered alongside instr under the same stall/flush/reset rules, reset value 0. For slt, regwrite = decoded write AND cond_q AND (A3 != 0). All other instructions are unaffected.
- Without the macro: cond_in is ignored, there is no register, and slt writes unconditionally.

Decomposition:
- Shared package mips_pkg:
  - opcode and funct constants (OP_R, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_JAL, OP_J, FN_ADDU, FN_SUBU, FN_SLT, FN_JR);
  - wd_sel encodings WD_ALU, WD_DM, WD_PC8;
  - field-slice constants.
- One sub-module, instr_decode: purely combinational, instr -> {A3, wr, wd_sel, tnew_base, is_slt}. The same module is reused by the D-stage controller.
- The pipeline register, Tnew offset and retire counter stay in pipe_stage_ctrl.

Test Plan:
- STAGE=1, load addu $3,$1,$2 (0x00221821), valid_in=1 -> next cycle A3=3, regwrite=1, wd_sel=0, Tnew=1.
- STAGE=2, load lw $5,4($0) (0x8C050004) -> A3=5, wd_sel=1, Tnew=1; same instr with STAGE=3 -> Tnew=0.
- STAGE=3, load jal (0x0C000010) -> A3=31, wd_sel=2, regwrite=1; then ori $0,$0,1 (0x34000001) -> A3=0, regwrite=0.
- Hold: stall=1 for 3 cycles while instr_in changes -> outputs unchanged, retire_cnt unchanged. Assert stall and flush together -> valid=0, instr=0.
- STAGE=3, CNT_W=4, 17 valid loads -> retire_cnt=1 (wraps). Assert reset mid-sequence -> retire_cnt=0 and valid=0 next cycle.
- COND_WB_EN: slt with cond_in=0 -> regwrite=0; with cond_in=1 -> regwrite=1. Without the macro -> regwrite=1 in both cases.
